// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: widens an IN_W-bit immediate to OUT_W bits
// (zero / sign / upper / branch) and carries it through STAGES register slices.
module imm_extend_pipe #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data_immD,
  input  logic [1:0]       i_con_mode,
  input  logic             i_con_stall,
  input  logic             i_con_flush,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data_immD,
  output logic [1:0]       o_con_mode
);

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("imm_extend_pipe: STAGES must be in 1..3");
  end
  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;
  logic [OUT_W-1:0] ext_data;
  logic [1:0]       ext_mode;

  assign zext   = {{PAD_W{1'b0}}, i_data_immD};
  assign sext   = {{PAD_W{i_data_immD[IN_W-1]}}, i_data_immD};
  assign upper  = {i_data_immD, {PAD_W{1'b0}}};
  // Top two sign-extended bits fall off: truncation is intentional.
  assign branch = {sext[OUT_W-3:0], 2'b00};

  always_comb begin
    ext_data = '0;
    ext_mode = '0;
    if (i_valid) begin
      ext_mode = i_con_mode;
      unique case (i_con_mode)
        2'b00:   ext_data = zext;
        2'b01:   ext_data = sext;
        2'b10:   ext_data = upper;
        default: ext_data = branch;
      endcase
    end
  end

  logic             valid_q [STAGES];
  logic [OUT_W-1:0] data_q  [STAGES];
  logic [1:0]       mode_q  [STAGES];

  // Reset beats flush, flush beats stall; both clear every slice to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_con_flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        mode_q[i]  <= '0;
      end
    end else if (!i_con_stall) begin
      valid_q[0] <= i_valid;
      data_q[0]  <= ext_data;
      mode_q[0]  <= ext_mode;
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        mode_q[i]  <= mode_q[i-1];
      end
    end
  end

  assign o_valid     = valid_q[STAGES-1];
  assign o_data_immD = data_q[STAGES-1];
  assign o_con_mode  = mode_q[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: four instances (1/2/3 stages, narrow)
// share control inputs; each task checks {valid, mode, data} at the outputs.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] imm;
  logic [7:0]  imm8;
  logic [1:0]  mode;
  logic        stall;
  logic        flush;

  logic        v1, v2, v3, v4;
  logic [31:0] d1, d2, d3;
  logic [11:0] d4;
  logic [1:0]  m1, m2, m3, m4;

  int checks;
  int failures;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data_immD(imm),
    .i_con_mode(mode), .i_con_stall(stall), .i_con_flush(flush),
    .o_valid(v1), .o_data_immD(d1), .o_con_mode(m1));

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data_immD(imm),
    .i_con_mode(mode), .i_con_stall(stall), .i_con_flush(flush),
    .o_valid(v2), .o_data_immD(d2), .o_con_mode(m2));

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data_immD(imm),
    .i_con_mode(mode), .i_con_stall(stall), .i_con_flush(flush),
    .o_valid(v3), .o_data_immD(d3), .o_con_mode(m3));

  imm_extend_pipe #(.IN_W(8), .OUT_W(12), .STAGES(1)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data_immD(imm8),
    .i_con_mode(mode), .i_con_stall(stall), .i_con_flush(flush),
    .o_valid(v4), .o_data_immD(d4), .o_con_mode(m4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [1:0] md);
    valid = v;
    imm   = x;
    mode  = md;
  endtask

  task automatic drain();
    drive(1'b0, 16'h0, 2'b00);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    logic [34:0] exp;
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 2'b01);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({v1, m1, d1} !== 35'h0) begin
        failures++;
        $display("FAIL reset_s1 got=%h exp=%h", {v1, m1, d1}, 35'h0);
      end
      checks++;
      if ({v3, m3, d3} !== 35'h0) begin
        failures++;
        $display("FAIL reset_s3 got=%h exp=%h", {v3, m3, d3}, 35'h0);
      end
    end
    rst = 1'b0;
    exp = {1'b1, 2'b01, 32'hFFFFFFFF};
    step();
    checks++;
    if ({v1, m1, d1} !== exp) begin
      failures++;
      $display("FAIL first_capture_s1 got=%h exp=%h", {v1, m1, d1}, exp);
    end
    checks++;
    if (v3 !== 1'b0) begin
      failures++;
      $display("FAIL latency_s3_c1 got=%b exp=0", v3);
    end
    step();
    checks++;
    if (v3 !== 1'b0) begin
      failures++;
      $display("FAIL latency_s3_c2 got=%b exp=0", v3);
    end
    step();
    checks++;
    if ({v3, m3, d3} !== exp) begin
      failures++;
      $display("FAIL latency_s3_c3 got=%h exp=%h", {v3, m3, d3}, exp);
    end
    drain();
  endtask

  task automatic test_modes();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h00008004;
    exp_d[1] = 32'hFFFF8004;
    exp_d[2] = 32'h80040000;
    exp_d[3] = 32'hFFFE0010;
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 16'h8004, 2'(m));
      step();
      checks++;
      if ({v1, m1, d1} !== {1'b1, 2'(m), exp_d[m]}) begin
        failures++;
        $display("FAIL mode_%0d got=%h exp=%h", m, {v1, m1, d1}, {1'b1, 2'(m), exp_d[m]});
      end
    end
    drain();
  endtask

  task automatic test_branch();
    drive(1'b1, 16'h7FFF, 2'b11);
    step();
    checks++;
    if ({v1, m1, d1} !== {1'b1, 2'b11, 32'h0001FFFC}) begin
      failures++;
      $display("FAIL branch_pos got=%h exp=%h", {v1, m1, d1}, {1'b1, 2'b11, 32'h0001FFFC});
    end
    imm8 = 8'h80;
    drive(1'b1, 16'h0, 2'b01);
    step();
    checks++;
    if ({v4, m4, d4} !== {1'b1, 2'b01, 12'hF80}) begin
      failures++;
      $display("FAIL narrow_sign got=%h exp=%h", {v4, m4, d4}, {1'b1, 2'b01, 12'hF80});
    end
    drive(1'b1, 16'h0, 2'b11);
    step();
    checks++;
    if ({v4, m4, d4} !== {1'b1, 2'b11, 12'hE00}) begin
      failures++;
      $display("FAIL narrow_branch got=%h exp=%h", {v4, m4, d4}, {1'b1, 2'b11, 12'hE00});
    end
    imm8 = 8'h00;
    drain();
  endtask

  task automatic test_stall();
    logic [34:0] ea, eb, ec;
    ea = {1'b1, 2'b00, 32'h00000011};
    eb = {1'b1, 2'b01, 32'hFFFF8001};
    ec = {1'b1, 2'b10, 32'h01230000};
    drive(1'b1, 16'h0011, 2'b00);
    step();
    drive(1'b1, 16'h8001, 2'b01);
    step();
    checks++;
    if ({v2, m2, d2} !== ea) begin
      failures++;
      $display("FAIL stall_pre got=%h exp=%h", {v2, m2, d2}, ea);
    end
    stall = 1'b1;
    drive(1'b1, 16'h0123, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({v2, m2, d2} !== ea) begin
        failures++;
        $display("FAIL stall_hold_%0d got=%h exp=%h", i, {v2, m2, d2}, ea);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if ({v2, m2, d2} !== eb) begin
      failures++;
      $display("FAIL stall_post_b got=%h exp=%h", {v2, m2, d2}, eb);
    end
    drive(1'b0, 16'h0, 2'b00);
    step();
    checks++;
    if ({v2, m2, d2} !== ec) begin
      failures++;
      $display("FAIL stall_post_c got=%h exp=%h", {v2, m2, d2}, ec);
    end
    step();
    checks++;
    if ({v2, m2, d2} !== 35'h0) begin
      failures++;
      $display("FAIL stall_no_dup got=%h exp=%h", {v2, m2, d2}, 35'h0);
    end
    drain();
  endtask

  task automatic test_flush();
    logic [34:0] ep;
    ep = {1'b1, 2'b00, 32'h00000055};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 2'b01);
      step();
    end
    checks++;
    if (v3 !== 1'b1) begin
      failures++;
      $display("FAIL flush_full got=%b exp=1", v3);
    end
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 16'hAAAA, 2'b10);
    step();
    stall = 1'b0;
    flush = 1'b0;
    checks++;
    if ({v3, m3, d3} !== 35'h0) begin
      failures++;
      $display("FAIL flush_empty got=%h exp=%h", {v3, m3, d3}, 35'h0);
    end
    drive(1'b1, 16'h0055, 2'b00);
    step();
    drive(1'b0, 16'h0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({v3, m3, d3} !== 35'h0) begin
        failures++;
        $display("FAIL flush_gap_%0d got=%h exp=%h", i, {v3, m3, d3}, 35'h0);
      end
      step();
    end
    checks++;
    if ({v3, m3, d3} !== ep) begin
      failures++;
      $display("FAIL flush_post got=%h exp=%h", {v3, m3, d3}, ep);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [34:0] eq;
    eq = {1'b1, 2'b10, 32'h00770000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h2000 + 16'(i), 2'b00);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({v3, m3, d3} !== 35'h0) begin
      failures++;
      $display("FAIL rst_mid_s3 got=%h exp=%h", {v3, m3, d3}, 35'h0);
    end
    checks++;
    if ({v2, m2, d2} !== 35'h0) begin
      failures++;
      $display("FAIL rst_mid_s2 got=%h exp=%h", {v2, m2, d2}, 35'h0);
    end
    drive(1'b1, 16'h0077, 2'b10);
    step();
    drive(1'b0, 16'h0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (v3 !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_stale_%0d got=%b exp=0", i, v3);
      end
      step();
    end
    checks++;
    if ({v3, m3, d3} !== eq) begin
      failures++;
      $display("FAIL rst_mid_post got=%h exp=%h", {v3, m3, d3}, eq);
    end
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    valid = 1'b0;
    imm   = '0;
    imm8  = '0;
    mode  = '0;
    stall = 1'b0;
    flush = 1'b0;
    test_reset();
    test_modes();
    test_branch();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-generation unit for the decode (D) stage of the ARC MIPS core.
- Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero-extend, sign-extend, upper (LUI) or branch offset (sign-extend then shift left 2).
- Result is registered through STAGES pipeline registers.
- Supports the hazard unit's global stall and flush controls.

Parameters:
- IN_W, 16: immediate input width.
- OUT_W, 32: output width. Legal only when OUT_W >= IN_W+2.
- STAGES, 1: pipeline depth, 1..3. Values outside this range, or an illegal OUT_W, must cause an elaboration-time $error.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  the immediate on i_data_immD is valid this cycle.
- i_data_immD  input  IN_W  raw immediate field.
- i_con_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
- i_con_stall  input  1  freeze the whole pipeline.
- i_con_flush  input  1  invalidate all in-flight entries.
- o_valid  output  1  o_data_immD is valid.
- o_data_immD  output  OUT_W  extended immediate.
- o_con_mode  output  2  mode that travelled with the result.

Behaviour:
- Clocking and reset: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset values: while i_rst=1 at a rising edge, every stage's valid, data and mode register clears to 0, so o_valid=0, o_data_immD=0, o_con_mode=2'b00. Reset mid-operation discards all in-flight entries. First capture is possible on the edge after i_rst falls.
- Combinational extension, computed on stage-0 inputs:
  - 00 zero: {(OUT_W-IN_W) zeros, imm}.
  - 01 sign: {(OUT_W-IN_W) copies of imm[IN_W-1], imm}.
  - 10 upper: imm placed in bits [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - 11 branch: sign-extended value shifted left by 2, bits [1:0]=0. Truncation to OUT_W is silent.
- Pipeline: STAGES cascaded register slices, each holding {valid, data, mode}. Output ports are driven directly from the last slice.
- Latency: exactly STAGES cycles from capture at stage 0 to o_valid, when no stall occurs.
- Advance: when i_con_stall=0 and i_con_flush=0, every slice loads from its predecessor. Stage 0 loads i_valid, the extended value and i_con_mode.
- Bubbles: when i_valid=0, stage 0 loads valid=0 with data=0 and mode=0. Bubbles propagate like normal entries.
- Stall (i_con_stall=1, i_con_flush=0): all slices hold their contents. Inputs are ignored. Outputs stay constant for as many cycles as the stall lasts.
- Flush (i_con_flush=1): all valid bits clear on that edge and data/mode clear to 0. The input that cycle is dropped.
- Flush and stall together: flush wins; the pipeline is emptied.
- Reset and flush/stall together: reset wins.
- No backpressure beyond stall; o_valid is not a handshake. Downstream consumes the result on any cycle with o_valid=1 and stall=0.
- No internal FSM other than per-slice valid tracking. No X may propagate onto outputs after reset.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with i_valid=1, imm=16'hFFFF. Required: o_valid=0, o_data_immD=0 throughout. Release reset; o_valid rises STAGES cycles after the first capture.
- Modes, default params: imm=16'h8004 in modes 00/01/10/11 on back-to-back cycles. Required outputs in order: 32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010. o_con_mode must match each result, with no gaps.
- Positive branch: imm=16'h7FFF, mode 11. Required: 32'h0001FFFC. Also run with IN_W=8, OUT_W=12, imm=8'h80, mode 01. Required: 12'hF80.
- Stall: STAGES=2, issue three valid entries, assert stall for 3 cycles mid-stream. Required: outputs frozen during the stall, then the remaining entries emerge in order with no loss or duplication.
- Flush priority: STAGES=3, pipeline full, assert stall and flush together for 1 cycle. Required: next cycle o_valid=0 and o_data_immD=0. Only post-flush inputs ever appear at the output.
- Reset mid-stream: pipeline full, i_rst=1 for 1 cycle. Required: all outputs 0 the following cycle and no pre-reset entry ever appears.
